// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched: round-robin burst read scheduler on the read side of a FIFO.
//
// A requester is picked in IDLE by round-robin starting after the last
// winner and is granted for a burst of blen+1 words. While in BURST, words
// flow from the FIFO head to the granted requester whenever the FIFO is
// non-empty, the requester still requests and it is ready. A burst finishes
// with a done pulse on its last transfer. It ends early with an abort pulse
// when the requester drops req, or when TMO cycles pass without a transfer.
//
// Ports:
//   rclk    in   read-domain clock, rising edge
//   rrst    in   asynchronous active-high reset
//   req     in   [NREQ]         per-requester burst request (level)
//   blen    in   [NREQ*BLEN_W]  per-requester burst length minus one
//   rdy     in   [NREQ]         per-requester ready to accept a word
//   rempty  in   FIFO empty flag
//   rdata   in   [DSIZE]        FIFO head word
//   ren     out  FIFO read enable (asserted exactly on a transfer)
//   dout    out  [DSIZE]        data to consumers (same as rdata)
//   dvalid  out  [NREQ]         per-requester word valid, at most one set
//   gnt     out  [NREQ]         registered one-hot grant
//   done    out  one-cycle pulse on the final transfer of a burst
//   abort   out  one-cycle pulse when a burst is cut short
module fifo_rd_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned BLEN_W = 4,
    parameter int unsigned TMO    = 15
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BLEN_W-1:0]   blen,
    input  logic [NREQ-1:0]          rdy,
    input  logic                     rempty,
    input  logic [DSIZE-1:0]         rdata,
    output logic                     ren,
    output logic [DSIZE-1:0]         dout,
    output logic [NREQ-1:0]          dvalid,
    output logic [NREQ-1:0]          gnt,
    output logic                     done,
    output logic                     abort
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {IDLE, BURST} state_t;

    state_t            state;
    logic [IW-1:0]     last;
    logic [IW-1:0]     win;
    logic [BLEN_W-1:0] cnt;
    logic [7:0]        tmo;

    logic              any_req;
    logic [IW-1:0]     next_win;
    logic [NREQ-1:0]   next_onehot;

    // Round-robin pick: first set req bit searching upward from last+1, wrapping.
    always_comb begin
        any_req     = 1'b0;
        next_win    = '0;
        next_onehot = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            if (!any_req && req[(int'(last) + i) % int'(NREQ)]) begin
                any_req  = 1'b1;
                next_win = IW'((int'(last) + i) % int'(NREQ));
            end
        end
        next_onehot[next_win] = 1'b1;
    end

    // Transfer path is combinational so a word moves in the same cycle it is
    // offered; gnt gates it so nothing moves in IDLE or during reset.
    always_comb begin
        dvalid = '0;
        if (state == BURST) begin
            dvalid = gnt & req & {NREQ{~rempty}};
        end
        ren  = |(dvalid & rdy);
        dout = rdata;
        done = ren && (cnt == '0);

        // Dropped req takes priority; abort only when no transfer, so it is
        // mutually exclusive with done.
        abort = 1'b0;
        if (state == BURST) begin
            if (!req[win]) begin
                abort = 1'b1;
            end else if (!ren && (tmo == 8'(TMO - 1))) begin
                abort = 1'b1;
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            tmo   <= '0;
            last  <= IW'(NREQ - 1);
            win   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt   <= next_onehot;
                        win   <= next_win;
                        cnt   <= blen[next_win*BLEN_W +: BLEN_W];
                        tmo   <= '0;
                        state <= BURST;
                    end else begin
                        gnt <= '0;
                    end
                end
                BURST: begin
                    if (done || abort) begin
                        last  <= win;
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (ren) begin
                        cnt <= cnt - 1'b1;
                        tmo <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: a per-cycle vector table for round-robin
// single-word bursts and a 4-word burst, then hand-written sequences for
// empty stalls, idle timeout, requester drop and mid-burst reset.
module tb_fifo_rd_sched;

    logic        rclk = 1'b0;
    logic        rrst;
    logic [3:0]  req;
    logic [15:0] blen;
    logic [3:0]  rdy;
    logic        rempty;
    logic [7:0]  rdata;
    logic        ren;
    logic [7:0]  dout;
    logic [3:0]  dvalid;
    logic [3:0]  gnt;
    logic        done;
    logic        abort;

    int checks   = 0;
    int failures = 0;

    fifo_rd_sched #(
        .NREQ   (4),
        .DSIZE  (8),
        .BLEN_W (4),
        .TMO    (15)
    ) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .req    (req),
        .blen   (blen),
        .rdy    (rdy),
        .rempty (rempty),
        .rdata  (rdata),
        .ren    (ren),
        .dout   (dout),
        .dvalid (dvalid),
        .gnt    (gnt),
        .done   (done),
        .abort  (abort)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] blen;
        logic [3:0]  rdy;
        logic        rempty;
        logic [7:0]  rdata;
        logic [3:0]  gnt;
        logic        ren;
        logic [3:0]  dvalid;
        logic        done;
        logic        abort;
    } vec_t;

    vec_t vt[16];

    task automatic check_outs(input string n, input logic [3:0] eg, input logic er,
                              input logic [3:0] edv, input logic ed, input logic ea);
        checks += 5;
        if (gnt !== eg) begin
            failures++;
            $display("FAIL %s gnt: got %b expected %b", n, gnt, eg);
        end
        if (ren !== er) begin
            failures++;
            $display("FAIL %s ren: got %b expected %b", n, ren, er);
        end
        if (dvalid !== edv) begin
            failures++;
            $display("FAIL %s dvalid: got %b expected %b", n, dvalid, edv);
        end
        if (done !== ed) begin
            failures++;
            $display("FAIL %s done: got %b expected %b", n, done, ed);
        end
        if (abort !== ea) begin
            failures++;
            $display("FAIL %s abort: got %b expected %b", n, abort, ea);
        end
    endtask

    task automatic check_dout(input string n, input logic [7:0] ed);
        checks++;
        if (dout !== ed) begin
            failures++;
            $display("FAIL %s dout: got %h expected %h", n, dout, ed);
        end
    endtask

    task automatic next_cycle();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        // Round-robin, all requesting, single-word bursts: grants 0,1,2,3,0.
        vt[0]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h10, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[1]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h11, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0};
        vt[2]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h12, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[3]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h13, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0};
        vt[4]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h14, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[5]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h15, 4'h4, 1'b1, 4'h4, 1'b1, 1'b0};
        vt[6]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h16, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[7]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h17, 4'h8, 1'b1, 4'h8, 1'b1, 1'b0};
        vt[8]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h18, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[9]  = '{4'hF, 16'h0000, 4'hF, 1'b0, 8'h19, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0};
        // Requester 2 alone, blen=3: four consecutive transfers, done on the 4th.
        vt[10] = '{4'h4, 16'h0300, 4'hF, 1'b0, 8'hA0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[11] = '{4'h4, 16'h0300, 4'hF, 1'b0, 8'hA1, 4'h4, 1'b1, 4'h4, 1'b0, 1'b0};
        vt[12] = '{4'h4, 16'h0300, 4'hF, 1'b0, 8'hA2, 4'h4, 1'b1, 4'h4, 1'b0, 1'b0};
        vt[13] = '{4'h4, 16'h0300, 4'hF, 1'b0, 8'hA3, 4'h4, 1'b1, 4'h4, 1'b0, 1'b0};
        vt[14] = '{4'h4, 16'h0300, 4'hF, 1'b0, 8'hA4, 4'h4, 1'b1, 4'h4, 1'b1, 1'b0};
        vt[15] = '{4'h0, 16'h0300, 4'hF, 1'b0, 8'hA5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};

        rrst   = 1'b1;
        req    = 4'h0;
        blen   = 16'h0000;
        rdy    = 4'hF;
        rempty = 1'b0;
        rdata  = 8'h00;
        #1;
        check_outs("reset", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rrst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req    = vt[i].req;
            blen   = vt[i].blen;
            rdy    = vt[i].rdy;
            rempty = vt[i].rempty;
            rdata  = vt[i].rdata;
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].gnt, vt[i].ren, vt[i].dvalid,
                       vt[i].done, vt[i].abort);
            check_dout($sformatf("vec%0d", i), vt[i].rdata);
            next_cycle();
        end

        // 4-word burst to requester 1 with FIFO empty in burst cycles 2 and 3.
        req  = 4'b0010;
        blen = 16'h0030;
        #1;
        check_outs("stall idle", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        for (int c = 1; c <= 6; c++) begin
            logic x;
            x      = (c != 2) && (c != 3);
            rempty = ~x;
            rdata  = 8'(8'h40 + c);
            #1;
            check_outs($sformatf("stall c%0d", c), 4'h2, x, x ? 4'h2 : 4'h0, c == 6, 1'b0);
            check_dout($sformatf("stall c%0d", c), 8'(8'h40 + c));
            if (c == 6) req = 4'h0;
            next_cycle();
        end
        rempty = 1'b0;
        #1;
        check_outs("stall end", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();

        // Idle timeout: FIFO stays empty, abort on the 15th BURST cycle.
        req    = 4'b0001;
        blen   = 16'h0000;
        rempty = 1'b1;
        #1;
        check_outs("tmo idle", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        for (int c = 1; c <= 15; c++) begin
            #1;
            check_outs($sformatf("tmo c%0d", c), 4'h1, 1'b0, 4'h0, 1'b0, c == 15);
            if (c == 15) req = 4'h0;
            next_cycle();
        end
        #1;
        check_outs("tmo end", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        rempty = 1'b0;
        next_cycle();

        // Requester 1 drops req after 2 of 8 words; rotation then favours 3.
        req  = 4'b1010;
        blen = 16'h0070;
        #1;
        check_outs("drop idle", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        #1;
        check_outs("drop w1", 4'h2, 1'b1, 4'h2, 1'b0, 1'b0);
        next_cycle();
        #1;
        check_outs("drop w2", 4'h2, 1'b1, 4'h2, 1'b0, 1'b0);
        next_cycle();
        req = 4'b1000;
        #1;
        check_outs("drop abort", 4'h2, 1'b0, 4'h0, 1'b0, 1'b1);
        next_cycle();
        req = 4'b1010;
        #1;
        check_outs("drop rearb", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        #1;
        check_outs("drop next", 4'h8, 1'b1, 4'h8, 1'b1, 1'b0);
        req = 4'h0;
        next_cycle();
        #1;
        check_outs("drop end", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();

        // Reset during word 3 of an 8-word burst to requester 2.
        req  = 4'b0100;
        blen = 16'h0700;
        #1;
        check_outs("rst idle", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            #1;
            check_outs($sformatf("rst w%0d", c), 4'h4, 1'b1, 4'h4, 1'b0, 1'b0);
            if (c < 3) next_cycle();
        end
        rrst = 1'b1;
        #1;
        check_outs("rst async", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        check_outs("rst held", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        rrst = 1'b0;
        req  = 4'b0101;
        #1;
        check_outs("rst release", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        next_cycle();
        #1;
        check_outs("rst regrant", 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        req = 4'h0;
        next_cycle();
        #1;
        check_outs("rst end", 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
